// File: rtl/rate_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : rate_sequencer
// Purpose : 48 kHz / decimated enables plus filter start/done handshake.
// Revision: 1.0  initial release
// ============================================================================
module rate_sequencer #(
  parameter int CLK_DIV = 2083,
  parameter int DIV_W   = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cfg_nfreq,
  input  logic       cfg_load,
  output logic [3:0] nfreq_active,
  output logic [3:0] phase,
  output logic       en48k,
  output logic       endecim,
  output logic       filt_start,
  input  logic       filt_done,
  output logic       busy,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic [7:0] drop_cnt
);

  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_en48k;
  logic             r_endecim;
  logic [3:0]       r_nfreq_active;
  logic [3:0]       r_phase;
  logic             r_pending;
  logic [3:0]       r_pending_val;
  logic             r_overrun;
  logic [7:0]       r_drop_cnt;
  state_t           r_state;
  state_t           w_state_nxt;

  logic             w_tick;
  logic             w_boundary;
  logic [3:0]       w_cfg_val;
  logic             w_filt_start;
  logic             w_busy;
  logic             w_drop;

  assign w_tick     = (r_div_cnt == C_DIV_LAST);
  assign w_boundary = w_tick && (r_phase == 4'd0);
  assign w_cfg_val  = (cfg_nfreq == 4'd0) ? 4'd1 : cfg_nfreq;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_en48k   <= 1'b0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      r_en48k   <= w_tick;
    end
  end

  // A cfg_load coinciding with the boundary stays pending for the next frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_endecim      <= 1'b0;
      r_nfreq_active <= 4'd1;
      r_phase        <= 4'd0;
      r_pending      <= 1'b0;
      r_pending_val  <= 4'd1;
    end else begin
      r_endecim <= w_boundary;
      if (w_boundary) begin
        if (r_pending) begin
          r_nfreq_active <= r_pending_val;
          r_phase        <= r_pending_val - 4'd1;
        end else begin
          r_phase        <= r_nfreq_active - 4'd1;
        end
      end else if (w_tick) begin
        r_phase <= r_phase - 4'd1;
      end
      if (cfg_load) begin
        r_pending_val <= w_cfg_val;
        r_pending     <= 1'b1;
      end else if (w_boundary && r_pending) begin
        r_pending     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_filt_start = 1'b0;
    w_busy       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_en48k) w_state_nxt = ST_START;
      end
      ST_START: begin
        w_filt_start = 1'b1;
        w_busy       = 1'b1;
        w_drop       = r_en48k;
        w_state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        w_drop = r_en48k;
        if (filt_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A drop on the clearing cycle wins: the counter restarts at one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overrun  <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
      if (overrun_clr)               r_drop_cnt <= 8'd1;
      else if (r_drop_cnt != 8'hFF)  r_drop_cnt <= r_drop_cnt + 8'd1;
    end else if (overrun_clr) begin
      r_overrun  <= 1'b0;
      r_drop_cnt <= 8'd0;
    end
  end

  assign nfreq_active = r_nfreq_active;
  assign phase        = r_phase;
  assign en48k        = r_en48k;
  assign endecim      = r_endecim;
  assign filt_start   = w_filt_start;
  assign busy         = w_busy;
  assign overrun      = r_overrun;
  assign drop_cnt     = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rate_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_rate_sequencer
// Purpose : Randomized self-checking bench for rate_sequencer (CLK_DIV=4).
// Revision: 1.0  initial release
// ============================================================================
module tb_rate_sequencer;

  localparam int CLK_DIV = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] cfg_nfreq;
  logic       cfg_load;
  logic [3:0] nfreq_active;
  logic [3:0] phase;
  logic       en48k;
  logic       endecim;
  logic       filt_start;
  logic       filt_done;
  logic       busy;
  logic       overrun;
  logic       overrun_clr;
  logic [7:0] drop_cnt;

  rate_sequencer #(.CLK_DIV(CLK_DIV), .DIV_W(12)) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_nfreq    (cfg_nfreq),
    .cfg_load     (cfg_load),
    .nfreq_active (nfreq_active),
    .phase        (phase),
    .en48k        (en48k),
    .endecim      (endecim),
    .filt_start   (filt_start),
    .filt_done    (filt_done),
    .busy         (busy),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .drop_cnt     (drop_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: values visible during the current cycle. Input-rate
  // timing is derived arithmetically from the cycle count since reset.
  bit m_valid = 1'b0;
  int m_cyc, m_phase, m_n, m_pval, m_drop;
  bit m_dec, m_pend, m_busy, m_start, m_ovr;

  function automatic bit m_en();
    return (m_cyc > 0) && (m_cyc % CLK_DIV == 0);
  endfunction

  task automatic model_update();
    bit en, tick, drop, nb;
    if (reset) begin
      m_valid = 1'b1; m_cyc = 0; m_dec = 1'b0; m_phase = 0; m_n = 1;
      m_pend = 1'b0; m_pval = 1; m_busy = 1'b0; m_start = 1'b0;
      m_ovr = 1'b0; m_drop = 0;
    end else begin
      en   = m_en();
      tick = (m_cyc % CLK_DIV) == (CLK_DIV - 1);
      drop = en && m_busy;
      m_dec = tick && (m_phase == 0);
      if (tick) begin
        if (m_phase == 0) begin
          if (m_pend) begin
            m_n = m_pval;
            m_pend = 1'b0;
          end
          m_phase = m_n - 1;
        end else begin
          m_phase = m_phase - 1;
        end
      end
      if (cfg_load) begin
        m_pval = (cfg_nfreq == 4'd0) ? 1 : int'(cfg_nfreq);
        m_pend = 1'b1;
      end
      nb = m_busy;
      if (en && !m_busy) nb = 1'b1;
      else if (m_busy && !m_start && filt_done) nb = 1'b0;
      m_start = en && !m_busy;
      m_busy  = nb;
      if (drop) begin
        m_ovr  = 1'b1;
        m_drop = overrun_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
      end else if (overrun_clr) begin
        m_ovr  = 1'b0;
        m_drop = 0;
      end
      m_cyc++;
    end
  endtask

  task automatic step();
    @(negedge clock);
    if (m_valid) begin
      chk("en48k",        32'(en48k),        32'(m_en()));
      chk("endecim",      32'(endecim),      32'(m_dec));
      chk("phase",        32'(phase),        32'(m_phase));
      chk("nfreq_active", 32'(nfreq_active), 32'(m_n));
      chk("filt_start",   32'(filt_start),   32'(m_start));
      chk("busy",         32'(busy),         32'(m_busy));
      chk("overrun",      32'(overrun),      32'(m_ovr));
      chk("drop_cnt",     32'(drop_cnt),     32'(m_drop));
    end
    model_update();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic rst, input logic ld, input logic [3:0] nf,
                     input logic dn, input logic clr);
    reset = rst; cfg_load = ld; cfg_nfreq = nf; filt_done = dn; overrun_clr = clr;
    step();
  endtask

  function automatic logic pct(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_nfreq"},   32'(nfreq_active), 32'd1);
    chk({tag, "_phase"},   32'(phase),        32'd0);
    chk({tag, "_en48k"},   32'(en48k),        32'd0);
    chk({tag, "_endecim"}, 32'(endecim),      32'd0);
    chk({tag, "_start"},   32'(filt_start),   32'd0);
    chk({tag, "_busy"},    32'(busy),         32'd0);
    chk({tag, "_overrun"}, 32'(overrun),      32'd0);
    chk({tag, "_drops"},   32'(drop_cnt),     32'd0);
  endtask

  initial begin
    bit found;
    reset = 1'b1; cfg_load = 1'b0; cfg_nfreq = 4'd0; filt_done = 1'b0; overrun_clr = 1'b0;
    @(posedge clock);
    #1;
    repeat (3) cyc(1, 0, 0, 0, 0);
    chk_reset_state("rst");

    // First en48k lands CLK_DIV cycles after reset release, with endecim.
    repeat (CLK_DIV - 1) cyc(0, 0, 0, 0, 0);
    chk("first_en48k_early", 32'(en48k), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("first_en48k",   32'(en48k),   32'd1);
    chk("first_endecim", 32'(endecim), 32'd1);

    repeat (40) cyc(0, 0, 0, pct(50), 0);

    // Mid-frame switch to N=3.
    repeat ($urandom_range(3, 1)) cyc(0, 0, 0, pct(50), 0);
    cyc(0, 1, 4'd3, pct(50), 0);
    repeat (60) cyc(0, 0, 0, pct(60), 0);
    chk("n3_active", 32'(nfreq_active), 32'd3);

    // Zero maps to one; back-to-back loads keep the last value.
    cyc(0, 1, 4'd0, pct(60), 0);
    repeat (30) cyc(0, 0, 0, pct(60), 0);
    chk("n0_active", 32'(nfreq_active), 32'd1);
    cyc(0, 1, 4'd5, pct(60), 0);
    cyc(0, 1, 4'd2, pct(60), 0);
    repeat (40) cyc(0, 0, 0, pct(60), 0);
    chk("last_load_wins", 32'(nfreq_active), 32'd2);

    // Held-off done, then mixed random traffic.
    repeat (10) cyc(0, 0, 0, 0, 0);
    repeat (400) cyc(0, pct(5), 4'($urandom_range(15, 0)), pct(15), pct(3));

    // filt_done arriving together with en48k while waiting.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_en() && m_busy && !m_start) begin
        found = 1'b1;
        cyc(0, 0, 0, 1, 0);
      end else begin
        cyc(0, 0, 0, 0, 0);
      end
    end
    chk("coincident_done_found", 32'(found), 32'd1);
    chk("coincident_done_busy",  32'(busy),  32'd0);

    // Clear coinciding with a drop.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_en() && m_busy) begin
        found = 1'b1;
        cyc(0, 0, 0, 0, 1);
      end else begin
        cyc(0, 0, 0, 0, 0);
      end
    end
    chk("clr_drop_found",   32'(found),    32'd1);
    chk("clr_drop_overrun", 32'(overrun),  32'd1);
    chk("clr_drop_cnt",     32'(drop_cnt), 32'd1);

    // Forced drops until the counter saturates.
    repeat (1300) cyc(0, 0, 0, 0, 0);
    chk("sat_cnt",     32'(drop_cnt), 32'd255);
    chk("sat_overrun", 32'(overrun),  32'd1);

    // Reset while waiting with phase==1, then a stray done.
    cyc(0, 1, 4'd2, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_busy && !m_start && m_phase == 1) begin
        found = 1'b1;
        cyc(1, 0, 0, 0, 0);
      end else begin
        cyc(0, 0, 0, 0, 0);
      end
    end
    chk("wait_phase1_found", 32'(found), 32'd1);
    chk_reset_state("midrst");
    cyc(0, 0, 0, 1, 0);
    chk("late_done_start", 32'(filt_start), 32'd0);
    chk("late_done_busy",  32'(busy),       32'd0);
    repeat (30) cyc(0, 0, 0, pct(40), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rate_sequencer.md
Name: rate_sequencer

Overview:
Sequences the audio decimation datapath. Derives the 48 kHz input clock-enable from the master clock, and the decimated output enable using a run-time divide factor that is shadowed and applied only at frame boundaries. It also hands each input sample to the multi-cycle anti-alias filter through a start/done handshake, and flags overruns. Sits between the clock domain root and the filter + downsample chain.

Parameters:
CLK_DIV, 2083, master clocks per 48 kHz sample period (legal range 2..4095).
DIV_W, 12, width of the internal clock-divider counter.

Ports:
clock  in  1  master clock
reset  in  1  reset, synchronous, active-high
cfg_nfreq  in  4  requested decimation factor; 0 is treated as 1
cfg_load  in  1  one-cycle pulse; captures cfg_nfreq into the pending register
nfreq_active  out  4  decimation factor currently in effect
phase  out  4  input samples remaining before the next decimated output
en48k  out  1  one-cycle input-rate enable (drives the datain enable of the chain)
endecim  out  1  one-cycle output-rate enable, coincident with the en48k that is kept
filt_start  out  1  one-cycle start pulse to the filter
filt_done  in  1  filter completion pulse
busy  out  1  filter handshake in progress
overrun  out  1  sticky: en48k arrived while the filter was busy
overrun_clr  in  1  clears overrun
drop_cnt  out  8  saturating count of dropped samples

Behaviour:
- Reset values: nfreq_active=1, pending flag=0, phase=0, div_cnt=0, en48k=0, endecim=0, filt_start=0, busy=0, overrun=0, drop_cnt=0, FSM=IDLE. Reset mid-operation aborts any handshake; no filt_start is issued on the cycle after reset.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. Internal tick = (div_cnt==CLK_DIV-1). en48k is registered: high for exactly the one cycle following each tick. Period is CLK_DIV cycles. The first en48k appears CLK_DIV cycles after reset deasserts.
- Config: cfg_load sets pending_val=(cfg_nfreq==0 ? 1 : cfg_nfreq) and pending=1. A later cfg_load before the value is applied overwrites pending_val (last wins).
- Phase, evaluated on tick:
  - If phase==0: endecim<=1. If pending, nfreq_active<=pending_val, pending<=0 and phase<=pending_val-1. Otherwise phase<=nfreq_active-1.
  - If phase!=0: endecim<=0 and phase<=phase-1.
  - endecim is 0 on all non-tick-following cycles.
  - A cfg_load on the same cycle as a tick with phase==0 is NOT applied at that boundary; it applies at the next one.
- Effect: with N=nfreq_active, endecim fires on en48k #1, #1+N, #1+2N, ... after reset. N=1 gives endecim on every en48k.
- Filter FSM:
  - IDLE -> START when en48k==1.
  - START: filt_start=1 for one cycle, busy=1 -> WAIT.
  - WAIT: busy=1; on filt_done -> IDLE. busy drops the cycle after filt_done.
  - filt_done in IDLE or START is ignored.
- Latency: filt_start asserts one cycle after en48k.
- Overrun: en48k while FSM in START or WAIT sets overrun=1 and drop_cnt+1 (saturates at 255). That sample gets no filt_start and nothing is queued.
  - filt_done and en48k on the same cycle in WAIT: FSM -> IDLE. The sample counts as a drop; it is not started.
  - overrun_clr clears overrun and drop_cnt. If set and clear coincide, set wins: overrun=1, drop_cnt=1.
- phase and nfreq_active outputs are the registered state values.

Test Plan:
- CLK_DIV=4, reset 3 cycles, cfg untouched -> en48k every 4 cycles, first one 4 cycles after reset release. endecim on every en48k (N=1). nfreq_active=1.
- cfg_nfreq=3, cfg_load mid-frame, filter returns done after 1 cycle -> switch to N=3 at the next phase==0 tick. endecim then on every 3rd en48k. phase sequence 2,1,0. One filt_start per en48k, 1 cycle later. overrun=0.
- cfg_nfreq=0 loaded -> nfreq_active=1, endecim every en48k. Then cfg_load 5 then 2 within one frame -> only 2 takes effect.
- filt_done held off for 10 cycles with CLK_DIV=4 -> overrun=1, drop_cnt=2, no filt_start for the dropped samples. filt_done coincident with en48k -> that sample dropped, drop_cnt=3.
- overrun_clr coincident with a drop event -> overrun=1, drop_cnt=1. 300 forced drops -> drop_cnt=255.
- reset asserted while FSM in WAIT and phase=1 -> all outputs at reset values next cycle. A late filt_done after reset is ignored. Divider restarts from 0.
